// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// One input bit is processed per clock. Signed inputs are converted as a sign flag plus a magnitude.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  input  logic                  signed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  neg_o
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [BW-1:0]    acc_reg, acc_adj, acc_next;
  logic [WIDTH-1:0] mag_reg, mag_in;
  logic             sign_reg, sign_in;
  logic [BW-1:0]    bcd_reg;
  logic             neg_reg;
  logic             last_iter;
  logic             busy_next, done_next;

  // The most negative value negates to itself; read as unsigned, that is the correct magnitude.
  assign sign_in = signed_i & bin_i[WIDTH-1];
  assign mag_in  = sign_in ? (~bin_i + WIDTH'(1)) : bin_i;

  // Each digit that is 5 or more gets 3 added before the shift, so it carries correctly.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_digit_adj
      assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                  (acc_reg[4*gi +: 4] + 4'd3) : acc_reg[4*gi +: 4];
    end
  endgenerate

  assign acc_next  = (acc_adj << 1) | BW'(mag_reg[WIDTH-1]);
  assign last_iter = (state_reg == SHIFT) && (cnt_reg == CW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) state_next = SHIFT;
      end
      SHIFT: begin
        busy_next = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        busy_next  = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg  <= '0;
      acc_reg  <= '0;
      mag_reg  <= '0;
      sign_reg <= 1'b0;
      bcd_reg  <= '0;
      neg_reg  <= 1'b0;
    end else begin
      if (state_reg == IDLE && start_i) begin
        cnt_reg  <= CW'(WIDTH);
        acc_reg  <= '0;
        mag_reg  <= mag_in;
        sign_reg <= sign_in;
      end else if (state_reg == SHIFT) begin
        cnt_reg <= cnt_reg - CW'(1);
        acc_reg <= acc_next;
        mag_reg <= mag_reg << 1;
        if (last_iter) begin
          bcd_reg <= acc_next;
          neg_reg <= sign_reg;
        end
      end
    end
  end

  assign busy_o = busy_next;
  assign done_o = done_next;
  assign bcd_o  = bcd_reg;
  assign neg_o  = neg_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and exhaustive bench for bin2bcd_seq (WIDTH=8, DIGITS=3).
// Each expected result goes into a scoreboard when its start is driven, and is checked when done_o pulses.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst, start, sgn;
  logic [7:0]  bin;
  logic        busy_o, done_o, neg_o;
  logic [11:0] bcd_o;

  typedef struct {
    logic [7:0]  bin;
    logic        sgn;
    logic [11:0] bcd;
    logic        neg;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          start_cyc = 0;
  int          dc0;
  logic [11:0] last_bcd = '0;
  logic        last_neg = 1'b0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bin_i(bin), .signed_i(sgn),
    .busy_o(busy_o), .done_o(done_o), .bcd_o(bcd_o), .neg_o(neg_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done_o === 1'b1) done_cnt++;

  function automatic exp_t model(input logic [7:0] b, input logic s);
    exp_t e;
    int   m;
    e.bin = b;
    e.sgn = s;
    e.neg = s & b[7];
    m     = e.neg ? 256 - int'(b) : int'(b);
    e.bcd = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] b, input logic s);
    bin   = b;
    sgn   = s;
    start = 1'b1;
    sb.push_back(model(b, s));
    tick();
    start     = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  task automatic finish_conv(input string tag);
    exp_t e;
    int   n   = 0;
    bit   got = 1'b0;
    while (n < 20 && !got) begin
      if (done_o === 1'b1) begin
        got = 1'b1;
      end else begin
        check({tag, "_hold"}, 32'({neg_o, bcd_o}), 32'({last_neg, last_bcd}));
        tick();
        n++;
      end
    end
    if (!got || sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout got no done_o exp done_o within 20 cycles", tag);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, 32'(cyc - start_cyc), 32'd8);
    check({tag, "_bcd"}, 32'(bcd_o), 32'(e.bcd));
    check({tag, "_neg"}, 32'(neg_o), 32'(e.neg));
    $display("conv %s bin=%h sgn=%0d bcd=%h neg=%0d", tag, e.bin, e.sgn, bcd_o, neg_o);
    last_bcd = e.bcd;
    last_neg = e.neg;
    tick();
    check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    check({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0; sgn = 1'b0;
    tick(); tick(); tick();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_bcd",  32'(bcd_o),  32'd0);
    check("rst_neg",  32'(neg_o),  32'd0);
    rst = 1'b0;
    tick();

    launch(8'hFF, 1'b0); finish_conv("u255");
    launch(8'hFF, 1'b1); finish_conv("s_m1");
    launch(8'h80, 1'b1); finish_conv("s_m128");
    launch(8'h00, 1'b1); finish_conv("s_zero");
    launch(8'd99, 1'b0); finish_conv("u99");

    // A start pulse in the middle of a conversion must not queue or restart anything.
    dc0 = done_cnt;
    launch(8'd200, 1'b0);
    tick(); tick();
    bin = 8'd7; start = 1'b1;
    tick();
    start = 1'b0; bin = 8'd0;
    finish_conv("ignore_start");
    repeat (12) tick();
    check("one_done_pulse", 32'(done_cnt - dc0), 32'd1);

    // Reset in mid-conversion
    launch(8'd150, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    dc0 = done_cnt;
    tick();
    rst = 1'b0;
    sb.delete();
    last_bcd = '0;
    last_neg = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_bcd",  32'(bcd_o),  32'd0);
    check("abort_neg",  32'(neg_o),  32'd0);
    repeat (10) tick();
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    launch(8'd42, 1'b0); finish_conv("after_abort");

    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 256; v++) begin
        launch(8'(v), 1'(s));
        finish_conv("sweep");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
